booth_display_ctrl: RTL and testbench

Sequencing controller for the 7-segment display of the Booth multiplier board.
- Accepts a signed product over a valid/ready handshake.
- Converts its magnitude to BCD sequentially (double-dabble, one bit per clk).
- Commits sign and digits atomically to display registers.
- Time-multiplexes the anodes, advancing one digit per rising edge of the 10 kHz divided clock from the clock divider.

---
 rtl/booth_display_ctrl_pkg.sv | 36 +++
 rtl/booth_display_ctrl_if.sv | 10 +
 rtl/booth_display_ctrl_bin2bcd.sv | 83 ++++++++
 rtl/booth_display_ctrl.sv | 90 +++++++++
 tb/tb_booth_display_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/booth_display_ctrl_pkg.sv
// Shared types and 7-segment glyph table for the Booth multiplier display.
// Glyphs are active-high gfedcba; the top level inverts them for the board.
package booth_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/booth_display_ctrl_if.sv
// Product hand-off from the multiplier to the display controller.
interface booth_display_ctrl_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] value;
    logic              value_valid;
    logic              value_ready;
    logic              busy;

    modport master (output value, value_valid, input value_ready, busy);
    modport slave  (input value, value_valid, output value_ready, busy);
endinterface

// File: rtl/booth_display_ctrl_bin2bcd.sv
// Sequential signed binary to BCD converter (double-dabble, one bit per clk).
// done is high during COMMIT so the caller latches sign/bcd on that edge.
module bin2bcd_seq
    import booth_disp_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       value,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic                    busy,
    output logic                    sign,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                  state;
    logic [DATA_W-1:0]       mag;
    logic [DATA_W-1:0]       abs_val;
    logic [4*BCD_DIGITS-1:0] work;
    logic [4*BCD_DIGITS-1:0] work_adj;
    logic [CNT_W-1:0]        cnt;
    logic                    neg;
    logic                    mag_zero;

    // The most negative input negates to itself, which read as unsigned is the right magnitude.
    assign abs_val = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;

    always_comb begin
        work_adj = work;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end

    assign bcd  = work;
    assign sign = neg & ~mag_zero;
    assign done = (state == COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            value_ready <= 1'b0;
            busy        <= 1'b0;
            mag         <= '0;
            work        <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            mag_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    value_ready <= 1'b1;
                    if (value_valid && value_ready) begin
                        neg         <= value[DATA_W-1];
                        mag         <= abs_val;
                        mag_zero    <= (value == '0);
                        work        <= '0;
                        cnt         <= CNT_W'(DATA_W);
                        value_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    {work, mag} <= {work_adj, mag} << 1;
                    cnt         <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    value_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/booth_display_ctrl.sv
// 7-segment controller: converts the signed product, holds it in display regs
// and scans the anodes one digit per rising edge of the divided scan clock.
module booth_display_ctrl
    import booth_disp_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int N_DIGITS   = 8,
    parameter int BCD_DIGITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_clk,
    booth_display_ctrl_if.slave bus,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                          conv_sign;
    logic [4*BCD_DIGITS-1:0]       conv_bcd;
    logic                          conv_done;
    logic                          disp_sign;
    logic [4*BCD_DIGITS-1:0]       disp_bcd;
    logic [2:0]                    scan_sync;
    logic                          scan_tick;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              msd;
    logic [N_DIGITS-1:0][6:0]      glyph;

    bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_DIGITS)) u_conv (
        .clk         (clk),
        .reset       (reset),
        .value       (bus.value),
        .value_valid (bus.value_valid),
        .value_ready (bus.value_ready),
        .busy        (bus.busy),
        .sign        (conv_sign),
        .bcd         (conv_bcd),
        .done        (conv_done)
    );

    // Two sync flops, one history flop, then a registered edge pulse: 3 clk latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_sync <= '0;
            scan_tick <= 1'b0;
            idx       <= '0;
            disp_sign <= 1'b0;
            disp_bcd  <= '0;
        end else begin
            scan_sync <= {scan_sync[1:0], scan_clk};
            scan_tick <= scan_sync[1] & ~scan_sync[2];
            if (scan_tick) idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            if (conv_done) begin
                disp_sign <= conv_sign;
                disp_bcd  <= conv_bcd;
            end
        end
    end

    // Most significant nonzero digit; 0 when the whole value is zero.
    always_comb begin
        msd = '0;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (disp_bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        if (d < BCD_DIGITS) begin : g_num
            assign glyph[d] = (d <= int'(msd))                     ? digit_to_seg(disp_bcd[4*d +: 4]) :
                              (disp_sign && d == int'(msd) + 1)    ? SEG_MINUS : SEG_BLANK;
        end else begin : g_pad
            assign glyph[d] = (disp_sign && d == int'(msd) + 1) ? SEG_MINUS : SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(N_DIGITS'(1) << idx);
            seg <= ~glyph[idx];
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_booth_display_ctrl.sv
// Directed bench for booth_display_ctrl: handshake timing, BCD digits, sign,
// blanking, busy hold-off, mid-conversion reset and scan wrap.
module tb_booth_display_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_clk = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;
    logic [6:0] e [8];

    booth_display_ctrl_if #(.DATA_W(16)) bus ();

    booth_display_ctrl #(.DATA_W(16), .N_DIGITS(8), .BCD_DIGITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .scan_clk (scan_clk),
        .bus      (bus),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan_clk period long enough for sync + tick + index + output register.
    task automatic scan_pulse();
        scan_clk = 1'b1;
        step(6);
        scan_clk = 1'b0;
        step(4);
    endtask

    task automatic read_all(input string tag, input logic [6:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s an%0d", tag, i), {24'd0, an}, {24'd0, 8'(~(8'd1 << i))});
            chk($sformatf("%s seg%0d", tag, i), {25'd0, seg}, {25'd0, exp[i]});
            scan_pulse();
        end
        chk($sformatf("%s dp", tag), {31'd0, dp}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (bus.value_ready !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        chk($sformatf("%s ready", tag), {31'd0, bus.value_ready}, 32'd1);
    endtask

    task automatic send(input string tag, input logic [15:0] v);
        int n = 0;
        wait_ready(tag);
        bus.value       = v;
        bus.value_valid = 1'b1;
        step(1);
        bus.value_valid = 1'b0;
        chk($sformatf("%s busy", tag), {31'd0, bus.busy}, 32'd1);
        while (bus.value_ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk($sformatf("%s ready_low", tag), n, 17);
        chk($sformatf("%s busy_end", tag), {31'd0, bus.busy}, 32'd0);
        step(2);
    endtask

    initial begin
        int n;
        bus.value       = '0;
        bus.value_valid = 1'b0;

        // Reset with scan activity
        step(1);
        for (int i = 0; i < 4; i++) begin
            scan_clk = ~scan_clk;
            step(3);
        end
        chk("rst an", {24'd0, an}, 32'hFF);
        chk("rst seg", {25'd0, seg}, 32'h7F);
        chk("rst dp", {31'd0, dp}, 32'd1);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("post ready", {31'd0, bus.value_ready}, 32'd1);
        chk("post an", {24'd0, an}, 32'hFE);
        chk("post seg", {25'd0, seg}, 32'h40);
        e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        read_all("zero", e);

        // 1234
        send("v1234", 16'd1234);
        e = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        read_all("v1234", e);

        // -16384
        send("vC000", 16'hC000);
        e = '{7'h19, 7'h00, 7'h30, 7'h02, 7'h79, 7'h3F, 7'h7F, 7'h7F};
        read_all("vC000", e);

        // -32768
        send("v8000", 16'h8000);
        e = '{7'h00, 7'h02, 7'h78, 7'h24, 7'h30, 7'h3F, 7'h7F, 7'h7F};
        read_all("v8000", e);

        // 5, with -1 held on valid during the conversion
        wait_ready("hold");
        bus.value       = 16'd5;
        bus.value_valid = 1'b1;
        step(1);
        bus.value = 16'hFFFF;
        chk("hold busy", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (bus.value_ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
            if (n == 8) chk("hold old_disp", {25'd0, seg}, 32'h00);
        end
        chk("hold ready_low", n, 17);
        chk("hold commit_edge", {25'd0, seg}, 32'h00);
        step(1);
        bus.value_valid = 1'b0;
        chk("hold new_disp", {25'd0, seg}, 32'h12);
        chk("hold second_busy", {31'd0, bus.busy}, 32'd1);
        chk("hold second_ready", {31'd0, bus.value_ready}, 32'd0);
        wait_ready("hold2");
        step(2);
        e = '{7'h79, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        read_all("vFFFF", e);

        // Reset on the 8th conversion cycle
        wait_ready("abort");
        bus.value       = 16'd999;
        bus.value_valid = 1'b1;
        step(1);
        bus.value_valid = 1'b0;
        step(8);
        reset = 1'b1;
        #1;
        chk("abort an", {24'd0, an}, 32'hFF);
        chk("abort seg", {25'd0, seg}, 32'h7F);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        step(3);
        reset = 1'b0;
        step(1);
        chk("abort ready", {31'd0, bus.value_ready}, 32'd1);
        chk("abort busy2", {31'd0, bus.busy}, 32'd0);
        chk("abort an2", {24'd0, an}, 32'hFE);
        chk("abort seg2", {25'd0, seg}, 32'h40);
        e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        read_all("abort", e);
        chk("wrap an", {24'd0, an}, 32'hFE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
